instr_byte_loader: RTL and testbench
====================================

# instr_byte_loader

Transmit-side counterpart of the instruction memory's byte-write port. Accepts 32-bit instruction words over a valid/ready handshake and serialises each into bytes on `write_Instruction`, framed by `write` (session enable) and a pulsed `write_Ready` strobe. It sits between a program source (boot ROM, UART receiver, debug port) and the instruction memory, and loads a program before the pipeline leaves reset.

## Interface
- `WORD_BYTES`, 4: bytes per instruction word.
- `STROBE_HIGH`, 1: cycles `write_Ready` is held high per byte; minimum 1.
- `STROBE_GAP`, 1: cycles `write_Ready` is held low after each byte; minimum 1, so the receiver sees a distinct edge.
- `MSB_FIRST`, 0: 0 sends `word_data[7:0]` first (little-endian); 1 sends `[31:24]` first.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a load session; sampled only in IDLE.
- `word_valid` in 1: source presents a word.
- `word_data` in 32: instruction word.
- `word_last` in 1: this word ends the session; sampled with the word.
- `word_ready` out 1: loader accepts a word this cycle.
- `write` out 1: session enable to the memory.
- `write_Instruction` out 8: current byte.
- `write_Ready` out 1: byte strobe.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at session end.
- `byte_count` out 16: bytes strobed in the current session; wraps modulo 2^16.

## Operation
- States:
  - IDLE: all outputs 0. On `start`, go to LOAD, clear `byte_count`, set `write` = 1.
  - LOAD: `word_ready` = 1. On `word_valid`, latch `word_data` into the shift register, latch `word_last`, set byte index = 0, go to STROBE.
  - STROBE: `write_Ready` = 1 for `STROBE_HIGH` cycles. `byte_count` increments once, on entry.
  - GAP: `write_Ready` = 0 for `STROBE_GAP` cycles. At the end:
    - if index < `WORD_BYTES-1`: shift to the next byte, index++, go to STROBE;
    - else if `word_last`: go to DONE;
    - else: go to LOAD.
  - DONE: `done` = 1 for one cycle, `write` drops to 0, go to IDLE.
- `write` stays 1 continuously from LOAD entry through the final GAP, including while stalled in LOAD waiting for the source.
- `write_Instruction` is registered and stable through the whole of STROBE and GAP. It changes only on the cycle STROBE is entered. In LOAD, IDLE and DONE it holds its last value.
- `word_ready` is high only in LOAD. A word is never accepted in the same cycle a byte is strobed.
- `start` outside IDLE is ignored. `word_valid` outside LOAD is ignored, and the source must hold the word.

## Timing
- Reset values: `word_ready` = 0, `write` = 0, `write_Instruction` = 8'h00, `write_Ready` = 0, `busy` = 0, `done` = 0, `byte_count` = 0. State is IDLE.
- `start` at cycle 0 gives `write` = 1 and `word_ready` = 1 at cycle 1.
- A word accepted at cycle t puts its first byte on `write_Instruction` with `write_Ready` = 1 at cycle t+1.
- Cycles per word = 1 + `WORD_BYTES`·(`STROBE_HIGH` + `STROBE_GAP`). With defaults this is 9.
- `done` rises on the cycle after the last GAP cycle of the `word_last` word. `write` is 0 on the following cycle.
- Reset asserted mid-session: all outputs clear immediately (asynchronous) and the partial word is discarded. After reset release the block idles until a new `start`.
- Back-to-back words: if `word_valid` is already high when LOAD is entered, acceptance happens on that first LOAD cycle, so there is no bubble beyond the one LOAD cycle.

## Structure
- Shared package `instr_loader_pkg` holds:
  - the state enum (IDLE, LOAD, STROBE, GAP, DONE);
  - default constants for `WORD_BYTES`, `STROBE_HIGH` and `STROBE_GAP`;
  - the `byte_count` width constant.
- One sub-module, `loader_strobe_timer`: a loadable down-counter that signals the end of the STROBE and GAP phases. The FSM, shift register and counters live in the top module.
- Parameter assertion: `STROBE_HIGH` ≥ 1, `STROBE_GAP` ≥ 1, `WORD_BYTES` ≥ 1.

## Test plan
- **Reset idle:** `rst` = 1, then release; hold 20 cycles with no `start` → all outputs stay 0, `busy` = 0.
- **Single word, defaults:** `start`, word 32'hD335_A1C4 with `word_last` = 1. Bytes observed on `write_Ready` rising edges are C4, A1, 35, D3. `write` stays high the whole time, `done` pulses 9 cycles after acceptance, `byte_count` = 4.
- **Byte order:** repeat the single-word case with `MSB_FIRST` = 1 → bytes are D3, 35, A1, C4.
- **Multi-word with source stall:** send three words, with `word_valid` dropped for 5 cycles before word 2. `write` never drops, `write_Ready` stays low during the stall, `byte_count` = 12, and exactly one `done` pulse occurs.
- **Strobe shaping:** `STROBE_HIGH` = 2, `STROBE_GAP` = 3 → each strobe is 2 cycles high and 3 low, and the byte is stable across all 5 cycles.
- **Reset mid-word:** assert `rst` during byte 2 → outputs clear in the same cycle. After a new `start` and word 32'h0000_0035, the first byte is 35 and `byte_count` restarts at 1.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and defaults for the instruction byte loader: FSM state encoding,
// default framing parameters and the byte counter width.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        GAP,
        DONE
    } load_state_e;

    localparam int DEF_WORD_BYTES  = 4;
    localparam int DEF_STROBE_HIGH = 1;
    localparam int DEF_STROBE_GAP  = 1;

    localparam int BYTE_COUNT_W = 16;

    // Width of a counter or index that must hold values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/loader_strobe_timer.sv
// Loadable down-counter timing the STROBE and GAP phases; expired_o is high while
// the count sits at zero, so a load value of N-1 gives a phase lasting N cycles.
module loader_strobe_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/instr_byte_loader.sv
// Serialises 32-bit instruction words into framed, strobed bytes for the
// instruction memory's byte-write port.
module instr_byte_loader
    import instr_loader_pkg::*;
#(
    parameter int WORD_BYTES  = DEF_WORD_BYTES,
    parameter int STROBE_HIGH = DEF_STROBE_HIGH,
    parameter int STROBE_GAP  = DEF_STROBE_GAP,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    word_valid,
    input  logic [8*WORD_BYTES-1:0] word_data,
    input  logic                    word_last,
    output logic                    word_ready,
    output logic                    write,
    output logic [7:0]              write_Instruction,
    output logic                    write_Ready,
    output logic                    busy,
    output logic                    done,
    output logic [BYTE_COUNT_W-1:0] byte_count
);

    localparam int WORD_W  = 8 * WORD_BYTES;
    localparam int IDX_W   = clog2_min1(WORD_BYTES);
    localparam int TMR_MAX = (STROBE_HIGH > STROBE_GAP) ? STROBE_HIGH : STROBE_GAP;
    localparam int TMR_W   = clog2_min1(TMR_MAX);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_BYTES - 1);
    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(STROBE_HIGH - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(STROBE_GAP - 1);

    if (WORD_BYTES < 1 || STROBE_HIGH < 1 || STROBE_GAP < 1) begin : g_param_check
        $error("instr_byte_loader: WORD_BYTES, STROBE_HIGH and STROBE_GAP must all be >= 1");
    end

    load_state_e             state_q, state_d;
    logic [BYTE_COUNT_W-1:0] byte_count_q, byte_count_d;
    logic [7:0]              instr_q, instr_d;
    logic [WORD_W-1:0]       shift_q, shift_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    last_q, last_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;

    function automatic logic [7:0] head_byte(input logic [WORD_W-1:0] w);
        return MSB_FIRST ? w[WORD_W-1 -: 8] : w[7:0];
    endfunction

    function automatic logic [WORD_W-1:0] drop_byte(input logic [WORD_W-1:0] w);
        return MSB_FIRST ? (w << 8) : (w >> 8);
    endfunction

    loader_strobe_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        instr_d      = instr_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        last_d       = last_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        word_ready   = 1'b0;
        write        = 1'b0;
        write_Ready  = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    byte_count_d = '0;
                    state_d      = LOAD;
                end
            end

            LOAD: begin
                word_ready = 1'b1;
                write      = 1'b1;
                if (word_valid) begin
                    instr_d      = head_byte(word_data);
                    shift_d      = drop_byte(word_data);
                    last_d       = word_last;
                    idx_d        = '0;
                    byte_count_d = byte_count_q + BYTE_COUNT_W'(1);
                    tmr_load     = 1'b1;
                    tmr_val      = HIGH_LOAD;
                    state_d      = STROBE;
                end
            end

            STROBE: begin
                write       = 1'b1;
                write_Ready = 1'b1;
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    state_d  = GAP;
                end
            end

            GAP: begin
                write = 1'b1;
                if (tmr_expired) begin
                    if (idx_q != IDX_LAST) begin
                        // The byte register only moves on STROBE entry, keeping it stable for the whole strobe/gap pair.
                        instr_d      = head_byte(shift_q);
                        shift_d      = drop_byte(shift_q);
                        idx_d        = idx_q + IDX_W'(1);
                        byte_count_d = byte_count_q + BYTE_COUNT_W'(1);
                        tmr_load     = 1'b1;
                        tmr_val      = HIGH_LOAD;
                        state_d      = STROBE;
                    end else if (last_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_count_q <= '0;
            instr_q      <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            instr_q      <= instr_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
        end
    end

    assign busy              = (state_q != IDLE);
    assign byte_count        = byte_count_q;
    assign write_Instruction = instr_q;

endmodule

// File: tb/tb_instr_byte_loader.sv
// Self-checking bench: three loader configurations (LSB-first, MSB-first, wide strobes)
// driven by randomized sessions and compared against a byte-list and timing model.
module tb_instr_byte_loader;

    localparam int WB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [2:0]           start_v;
    logic [2:0]           valid_v;
    logic [2:0]           last_v;
    logic [2:0][31:0]     data_v;
    wire  [2:0]           ready_v;
    wire  [2:0]           write_v;
    wire  [2:0]           wr_v;
    wire  [2:0]           busy_v;
    wire  [2:0]           done_v;
    wire  [2:0][7:0]      instr_v;
    wire  [2:0][15:0]     bc_v;

    int checks = 0;
    int errors = 0;

    logic [31:0] sw[$];
    int          ss[$];

    instr_byte_loader #(.WORD_BYTES(WB), .STROBE_HIGH(1), .STROBE_GAP(1), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start_v[0]), .word_valid(valid_v[0]), .word_data(data_v[0]),
        .word_last(last_v[0]), .word_ready(ready_v[0]), .write(write_v[0]), .write_Instruction(instr_v[0]),
        .write_Ready(wr_v[0]), .busy(busy_v[0]), .done(done_v[0]), .byte_count(bc_v[0]));

    instr_byte_loader #(.WORD_BYTES(WB), .STROBE_HIGH(1), .STROBE_GAP(1), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start_v[1]), .word_valid(valid_v[1]), .word_data(data_v[1]),
        .word_last(last_v[1]), .word_ready(ready_v[1]), .write(write_v[1]), .write_Instruction(instr_v[1]),
        .write_Ready(wr_v[1]), .busy(busy_v[1]), .done(done_v[1]), .byte_count(bc_v[1]));

    instr_byte_loader #(.WORD_BYTES(WB), .STROBE_HIGH(2), .STROBE_GAP(3), .MSB_FIRST(1'b0)) u_wide (
        .clk(clk), .rst(rst), .start(start_v[2]), .word_valid(valid_v[2]), .word_data(data_v[2]),
        .word_last(last_v[2]), .word_ready(ready_v[2]), .write(write_v[2]), .write_Instruction(instr_v[2]),
        .write_Ready(wr_v[2]), .busy(busy_v[2]), .done(done_v[2]), .byte_count(bc_v[2]));

    function automatic int h_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic int g_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int k);
        return (k == 1);
    endfunction

    function automatic logic [31:0] outs_of(input int k);
        return {3'b000, ready_v[k], write_v[k], wr_v[k], busy_v[k], done_v[k], bc_v[k], instr_v[k]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input int ncyc);
        repeat (ncyc) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) check($sformatf("idle_outputs_%0d", k), outs_of(k), 32'h0);
        end
    endtask

    // One session on instance k using words sw[] and per-word LOAD stalls ss[].
    // abort_at > 0 asserts reset while that byte (1-based) is being strobed.
    task automatic run_session(input int k, input int abort_at);
        int          n        = sw.size();
        int          hh       = h_of(k);
        int          gg       = g_of(k);
        int          cpw      = 1 + WB * (hh + gg);
        logic [7:0]  exp_b[$];
        logic [7:0]  obs_b[$];
        int          w        = 0;
        int          ready_cnt = 0;
        int          last_acc = 0;
        int          nbytes   = 0;
        int          last_rise = 0;
        int          hi_len   = 0;
        logic        prev_wr  = 1'b0;
        logic [7:0]  held     = 8'h00;
        bit          post_done = 0;
        bit          finished = 0;
        bit          aborted  = 0;
        logic        wr, rdy, offer;
        int          exp_acc, sh;

        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < WB; b++) begin
                sh = msb_of(k) ? 8 * (WB - 1 - b) : 8 * b;
                exp_b.push_back(8'(sw[i] >> sh));
            end
        end

        for (int c = 0; c < 400 && !finished; c++) begin
            @(negedge clk);
            wr  = wr_v[k];
            rdy = ready_v[k];

            if (c == 0) begin
                check("idle_before_start", {31'b0, busy_v[k]}, 32'h0);
            end else if (post_done) begin
                check("write_after_done", {31'b0, write_v[k]}, 32'h0);
                check("busy_after_done", {31'b0, busy_v[k]}, 32'h0);
                check("done_single_pulse", {31'b0, done_v[k]}, 32'h0);
                finished = 1;
            end else if (done_v[k]) begin
                check("done_time", c, last_acc + cpw);
                check("done_byte_count", {16'b0, bc_v[k]}, WB * n);
                post_done = 1;
            end else begin
                check("write_held", {31'b0, write_v[k]}, 32'h1);
                check("no_accept_while_strobe", {31'b0, rdy & wr}, 32'h0);
            end

            if (!finished && c > 0) begin
                if (wr && !prev_wr) begin
                    obs_b.push_back(instr_v[k]);
                    nbytes++;
                    check("byte_count_at_strobe", {16'b0, bc_v[k]}, nbytes);
                    if ((nbytes - 1) % WB == 0) check("first_byte_latency", c, last_acc + 1);
                    else                        check("strobe_period", c - last_rise, hh + gg);
                    last_rise = c;
                    held      = instr_v[k];
                end else if (nbytes > 0) begin
                    check("byte_stable", {24'b0, instr_v[k]}, {24'b0, held});
                end
                if (!wr && prev_wr) check("strobe_high_len", hi_len, hh);
                hi_len = wr ? hi_len + 1 : 0;

                if (abort_at > 0 && nbytes == abort_at && wr) begin
                    start_v[k] = 1'b0;
                    valid_v[k] = 1'b0;
                    rst = 1'b1;
                    #1;
                    check("async_reset_clear", outs_of(k), 32'h0);
                    @(negedge clk);
                    rst = 1'b0;
                    aborted  = 1;
                    finished = 1;
                end
            end

            if (!finished) begin
                start_v[k] = (c == 0);
                if (w < n) begin
                    offer      = (ready_cnt >= ss[w]);
                    valid_v[k] = offer;
                    data_v[k]  = sw[w];
                    last_v[k]  = (w == n - 1);
                    if (offer && rdy) begin
                        exp_acc = (w == 0) ? 1 + ss[0] : last_acc + cpw + ss[w];
                        check("accept_time", c, exp_acc);
                        last_acc  = c;
                        w++;
                        ready_cnt = 0;
                    end else if (rdy) begin
                        ready_cnt++;
                    end
                end else begin
                    valid_v[k] = 1'b0;
                    last_v[k]  = 1'b0;
                end
            end
            prev_wr = wr;
        end

        start_v[k] = 1'b0;
        valid_v[k] = 1'b0;
        last_v[k]  = 1'b0;
        if (!finished) check("session_timeout", 32'h0, 32'h1);
        if (!aborted) check("byte_total", obs_b.size(), exp_b.size());
        for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
            check($sformatf("byte_%0d", i), {24'b0, obs_b[i]}, {24'b0, exp_b[i]});
        end
    endtask

    task automatic random_words(input int n, input int max_stall);
        sw.delete();
        ss.delete();
        for (int i = 0; i < n; i++) begin
            sw.push_back($urandom());
            ss.push_back((i == 0) ? 0 : int'($urandom_range(0, max_stall)));
        end
    endtask

    initial begin
        rst     = 1'b0;
        start_v = '0;
        valid_v = '0;
        last_v  = '0;
        data_v  = '0;
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("reset_values_%0d", k), outs_of(k), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_check(20);

        sw = '{32'hD335_A1C4};
        ss = '{0};
        run_session(0, 0);
        run_session(1, 0);

        random_words(3, 0);
        ss[1] = 5;
        run_session(0, 0);

        random_words(2, 0);
        run_session(2, 0);

        for (int r = 0; r < 6; r++) begin
            random_words(int'($urandom_range(1, 3)), 3);
            run_session(r % 3, 0);
        end

        random_words(1, 0);
        run_session(0, 2);
        idle_check(5);
        sw = '{32'h0000_0035};
        ss = '{0};
        run_session(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
